// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode/issue stage: widths, instruction field
// positions, opcode / function / element-width constants and decode helpers.
// Instruction bit k of the ISA numbering (bit 0 = MSB) is if_instr[31-k] here,
// so the opcode sits in [31:26], rD in [25:21], rA in [20:16], rB in [15:11],
// WW in [7:6], function in [5:0] and the immediate in [15:0].
package id_ex_stage_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned OPC_W   = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned WW_W    = 2;
   localparam int unsigned IMM_W   = 16;

   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RD_LSB  = 21;
   localparam int unsigned RA_LSB  = 16;
   localparam int unsigned RB_LSB  = 11;
   localparam int unsigned WW_LSB  = 6;
   localparam int unsigned FN_LSB  = 0;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [OPC_W-1:0] OPC_R_ALU     = 6'b101010;
   localparam logic [OPC_W-1:0] OPC_LOAD      = 6'b100000;
   localparam logic [OPC_W-1:0] OPC_STORE     = 6'b100001;
   localparam logic [OPC_W-1:0] OPC_BRANCH_EZ = 6'b100010;
   localparam logic [OPC_W-1:0] OPC_BRANCH_NZ = 6'b100011;
   localparam logic [OPC_W-1:0] OPC_NOP       = 6'b111100;

   localparam logic [FN_W-1:0] FN_VAND  = 6'b000001;
   localparam logic [FN_W-1:0] FN_VOR   = 6'b000010;
   localparam logic [FN_W-1:0] FN_VXOR  = 6'b000011;
   localparam logic [FN_W-1:0] FN_VNOT  = 6'b000100;
   localparam logic [FN_W-1:0] FN_VMOV  = 6'b000101;
   localparam logic [FN_W-1:0] FN_VADD  = 6'b000110;
   localparam logic [FN_W-1:0] FN_VSUB  = 6'b000111;
   localparam logic [FN_W-1:0] FN_VDIV  = 6'b001110;
   localparam logic [FN_W-1:0] FN_VMOD  = 6'b001111;
   localparam logic [FN_W-1:0] FN_VSQRT = 6'b010010;

   localparam logic [WW_W-1:0] WW_B = 2'b00;
   localparam logic [WW_W-1:0] WW_H = 2'b01;
   localparam logic [WW_W-1:0] WW_W32 = 2'b10;
   localparam logic [WW_W-1:0] WW_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MC_WAIT  = 2'd1,
      ST_LU_STALL = 2'd2
   } hz_state_e;

   // Decoded fields carried into the ID/EX register
   typedef struct packed {
      logic [OPC_W-1:0]   op;
      logic [FN_W-1:0]    fn;
      logic [WW_W-1:0]    ww;
      logic [RADDR_W-1:0] rd;
      logic [IMM_W-1:0]   imm;
   } dec_fields_t;

   function automatic logic op_known(input logic [OPC_W-1:0] op);
      return (op == OPC_R_ALU) || (op == OPC_LOAD) || (op == OPC_STORE) ||
             (op == OPC_BRANCH_EZ) || (op == OPC_BRANCH_NZ) || (op == OPC_NOP);
   endfunction

   // Opcodes whose second source comes from the rD field
   function automatic logic rb_from_rd(input logic [OPC_W-1:0] op);
      return (op == OPC_STORE) || (op == OPC_BRANCH_EZ) || (op == OPC_BRANCH_NZ);
   endfunction

   function automatic logic rb_used(input logic [OPC_W-1:0] op);
      return (op == OPC_R_ALU) || rb_from_rd(op);
   endfunction

   function automatic logic fn_multicycle(input logic [FN_W-1:0] fn);
      return (fn == FN_VDIV) || (fn == FN_VMOD) || (fn == FN_VSQRT);
   endfunction

   // Unknown opcodes collapse to NOP so nothing downstream ever sees them
   function automatic dec_fields_t decode(input logic [INSTR_W-1:0] instr);
      dec_fields_t d;
      d     = '0;
      d.op  = instr[OPC_LSB +: OPC_W];
      if (!op_known(d.op)) d.op = OPC_NOP;
      d.fn  = instr[FN_LSB +: FN_W];
      d.ww  = instr[WW_LSB +: WW_W];
      d.rd  = instr[RD_LSB +: RADDR_W];
      d.imm = instr[IMM_LSB +: IMM_W];
      return d;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// id_hazard_unit: load-use / writeback-conflict stall detection, multi-cycle
// ALU occupancy counter, stage FSM and if_ready generation.
module id_hazard_unit
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned MC_LAT = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               if_valid,
   input  logic [OPC_W-1:0]   dec_op,
   input  logic [FN_W-1:0]    dec_fn,
   input  logic [RADDR_W-1:0] ra_addr,
   input  logic [RADDR_W-1:0] rb_addr,
   input  logic               rb_use,
   input  logic               wb_stall_c,
   input  logic               ex_valid,
   input  logic [OPC_W-1:0]   ex_op,
   input  logic [RADDR_W-1:0] ex_rd,
   output logic               if_ready,
   output logic               issue_c,
   output logic               hold_c
);

   localparam int unsigned CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 1);

   hz_state_e        state, state_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic             lu_hit_c, stall_c, mc_issue_c;

   // Hazard compare, ready and issue qualification
   always_comb begin
      lu_hit_c   = ex_valid && (ex_op == OPC_LOAD) &&
                   ((ex_rd == ra_addr) || (rb_use && (ex_rd == rb_addr)));
      stall_c    = if_valid && (dec_op != OPC_NOP) && (lu_hit_c || wb_stall_c);
      hold_c     = (count != '0);
      if_ready   = flush || (!hold_c && !stall_c);
      issue_c    = if_valid && if_ready && !flush;
      mc_issue_c = issue_c && (dec_op == OPC_R_ALU) && fn_multicycle(dec_fn);
   end

   // Next state and counter; flush overrides everything
   always_comb begin
      state_nx = state;
      count_nx = count;
      case (state)
         ST_IDLE: begin
            if (mc_issue_c) begin
               state_nx = ST_MC_WAIT;
               count_nx = MC_LOAD;
            end else if (stall_c) begin
               state_nx = ST_LU_STALL;
            end
         end
         ST_LU_STALL: begin
            if (mc_issue_c) begin
               state_nx = ST_MC_WAIT;
               count_nx = MC_LOAD;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_MC_WAIT: begin
            if (hold_c) begin
               count_nx = count - CNT_W'(1);
            end else if (mc_issue_c) begin
               count_nx = MC_LOAD;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            count_nx = '0;
         end
      endcase
      if (flush) begin
         state_nx = ST_IDLE;
         count_nx = '0;
      end
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue with ID/EX pipeline register feeding the vector
// ALU. Optional macro ID_EX_WB_BYPASS_EN forwards the writeback port into the
// operands; without it a writeback/read address conflict costs a one-cycle
// bubble and the read is retried from the register file.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned MC_LAT = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               if_valid,
   input  logic [INSTR_W-1:0] if_instr,
   output logic               if_ready,
   input  logic               flush,
   output logic [RADDR_W-1:0] rf_rA_addr,
   output logic [RADDR_W-1:0] rf_rB_addr,
   input  logic [DATA_W-1:0]  rf_rA_data,
   input  logic [DATA_W-1:0]  rf_rB_data,
   input  logic               wb_en,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               ex_valid,
   output logic               ex_busy,
   output logic [OPC_W-1:0]   ex_Op_code,
   output logic [FN_W-1:0]    ex_R_ins,
   output logic [WW_W-1:0]    ex_WW,
   output logic [RADDR_W-1:0] ex_rD,
   output logic [IMM_W-1:0]   ex_imm,
   output logic [DATA_W-1:0]  ex_rA_val,
   output logic [DATA_W-1:0]  ex_rB_val
);

   dec_fields_t       dec_c;
   logic              rb_use_c;
   logic              wb_hit_a_c, wb_hit_b_c, wb_stall_c;
   logic [DATA_W-1:0] ra_val_c, rb_val_c;
   logic              issue_c, hold_c;

   // Field decode and register-file read addresses
   always_comb begin
      dec_c      = decode(if_instr);
      rb_use_c   = rb_used(dec_c.op);
      rf_rA_addr = if_instr[RA_LSB +: RADDR_W];
      rf_rB_addr = rb_from_rd(dec_c.op) ? if_instr[RD_LSB +: RADDR_W]
                                        : if_instr[RB_LSB +: RADDR_W];
   end

   // Writeback conflict: forward it, or turn it into a stall request
   always_comb begin
      wb_hit_a_c = wb_en && (wb_addr == rf_rA_addr);
      wb_hit_b_c = wb_en && (wb_addr == rf_rB_addr);
`ifdef ID_EX_WB_BYPASS_EN
      ra_val_c   = wb_hit_a_c ? wb_data : rf_rA_data;
      rb_val_c   = wb_hit_b_c ? wb_data : rf_rB_data;
      wb_stall_c = 1'b0;
`else
      ra_val_c   = rf_rA_data;
      rb_val_c   = rf_rB_data;
      wb_stall_c = wb_hit_a_c || (rb_use_c && wb_hit_b_c);
`endif
   end

`ifndef ID_EX_WB_BYPASS_EN
   logic [DATA_W-1:0] unused_wb_data;
   assign unused_wb_data = wb_data;
`endif

   id_hazard_unit #(.MC_LAT(MC_LAT)) u_hazard (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .if_valid   (if_valid),
      .dec_op     (dec_c.op),
      .dec_fn     (dec_c.fn),
      .ra_addr    (rf_rA_addr),
      .rb_addr    (rf_rB_addr),
      .rb_use     (rb_use_c),
      .wb_stall_c (wb_stall_c),
      .ex_valid   (ex_valid),
      .ex_op      (ex_Op_code),
      .ex_rd      (ex_rD),
      .if_ready   (if_ready),
      .issue_c    (issue_c),
      .hold_c     (hold_c)
   );

   // ID/EX register: reset > flush > multi-cycle hold > issue > bubble
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_valid   <= 1'b0;
         ex_busy    <= 1'b0;
         ex_Op_code <= OPC_NOP;
         ex_R_ins   <= '0;
         ex_WW      <= '0;
         ex_rD      <= '0;
         ex_imm     <= '0;
         ex_rA_val  <= '0;
         ex_rB_val  <= '0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_busy    <= 1'b0;
         ex_Op_code <= OPC_NOP;
      end else if (hold_c) begin
         ex_valid   <= 1'b0;
         ex_busy    <= 1'b1;
      end else if (issue_c) begin
         ex_valid   <= 1'b1;
         ex_busy    <= 1'b0;
         ex_Op_code <= dec_c.op;
         ex_R_ins   <= dec_c.fn;
         ex_WW      <= dec_c.ww;
         ex_rD      <= dec_c.rd;
         ex_imm     <= dec_c.imm;
         ex_rA_val  <= ra_val_c;
         ex_rB_val  <= rb_val_c;
      end else begin
         ex_valid   <= 1'b0;
         ex_busy    <= 1'b0;
         ex_Op_code <= OPC_NOP;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (MC_LAT = 4). Stimulus pushes the expected
// ID/EX contents for each accepted instruction; a monitor pops on ex_valid,
// checks held contents while ex_busy and NOP opcode on bubbles.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [1:0]  ww;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [63:0] a;
      logic [63:0] b;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, if_valid, if_ready, flush, wb_en;
   logic [31:0] if_instr;
   logic [4:0]  rf_rA_addr, rf_rB_addr, wb_addr;
   logic [63:0] rf_rA_data, rf_rB_data, wb_data;
   logic        ex_valid, ex_busy;
   logic [5:0]  ex_Op_code, ex_R_ins;
   logic [1:0]  ex_WW;
   logic [4:0]  ex_rD;
   logic [15:0] ex_imm;
   logic [63:0] ex_rA_val, ex_rB_val;

   exp_t sb[$];
   exp_t last_issue = '0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.MC_LAT(4)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .if_ready(if_ready), .flush(flush),
      .rf_rA_addr(rf_rA_addr), .rf_rB_addr(rf_rB_addr),
      .rf_rA_data(rf_rA_data), .rf_rB_data(rf_rB_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_busy(ex_busy), .ex_Op_code(ex_Op_code),
      .ex_R_ins(ex_R_ins), .ex_WW(ex_WW), .ex_rD(ex_rD), .ex_imm(ex_imm),
      .ex_rA_val(ex_rA_val), .ex_rB_val(ex_rB_val)
   );

   // Register file contents: r1=5, r2=7, others 0x100+index
   function automatic logic [63:0] rfv(input logic [4:0] i);
      if (i == 5'd1) return 64'd5;
      if (i == 5'd2) return 64'd7;
      return 64'h100 + 64'(i);
   endfunction

   always_comb begin
      rf_rA_data = rfv(rf_rA_addr);
      rf_rB_data = rfv(rf_rB_addr);
   end

   function automatic logic [31:0] rins(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [1:0] ww);
      return {6'b101010, rd, ra, rb, 3'b000, ww, fn};
   endfunction

   function automatic logic [31:0] iins(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [15:0] imm);
      return {op, rd, ra, imm};
   endfunction

   function automatic exp_t mk(input logic [31:0] ins, input logic [63:0] a,
                               input logic [63:0] b);
      exp_t e;
      logic [5:0] op;
      op    = ins[31:26];
      e.op  = (op == 6'b101010 || op == 6'b100000 || op == 6'b100001 ||
               op == 6'b100010 || op == 6'b100011) ? op : 6'b111100;
      e.fn  = ins[5:0];
      e.ww  = ins[7:6];
      e.rd  = ins[25:21];
      e.imm = ins[15:0];
      e.a   = a;
      e.b   = b;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                        input logic rdy, input logic busy, input exp_t e);
      if_valid = v;
      if_instr = ins;
      flush    = fl;
      #2;
      chk("if_ready", 64'(if_ready), 64'(rdy));
      chk("ex_busy", 64'(ex_busy), 64'(busy));
      if (v && rdy && !fl) sb.push_back(e);
   endtask

   task automatic send(input logic v, input logic [31:0] ins, input logic fl,
                       input logic rdy, input logic busy, input exp_t e);
      cyc();
      drive(v, ins, fl, rdy, busy, e);
   endtask

   task automatic check_reset_vals();
      chk("rst_ex_valid", 64'(ex_valid), 64'd0);
      chk("rst_ex_busy", 64'(ex_busy), 64'd0);
      chk("rst_ex_Op_code", 64'(ex_Op_code), 64'h3C);
      chk("rst_ex_R_ins", 64'(ex_R_ins), 64'd0);
      chk("rst_ex_WW", 64'(ex_WW), 64'd0);
      chk("rst_ex_rD", 64'(ex_rD), 64'd0);
      chk("rst_ex_imm", 64'(ex_imm), 64'd0);
      chk("rst_ex_rA_val", ex_rA_val, 64'd0);
      chk("rst_ex_rB_val", ex_rB_val, 64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd1);
   endtask

   // Monitor: compare issued contents, held contents and bubbles
   initial begin
      exp_t e, act;
      forever begin
         @(negedge clk);
         act = {ex_Op_code, ex_R_ins, ex_WW, ex_rD, ex_imm, ex_rA_val, ex_rB_val};
         if (ex_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_issue: got %h expected no issue", act);
            end else begin
               e = sb.pop_front();
               last_issue = e;
               if (act === e) n_pass++;
               else $display("FAIL issue: got %h expected %h", act, e);
            end
         end else if (ex_busy) begin
            n_chk++;
            if (act === last_issue) n_pass++;
            else $display("FAIL busy_hold: got %h expected %h", act, last_issue);
         end else begin
            chk("bubble_nop", 64'(ex_Op_code), 64'h3C);
         end
      end
   end

   initial begin
      logic [31:0] ins, ld, filler;
      reset = 1'b0; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #2 check_reset_vals();

      // Basic VADD r3,r1,r2 WW=10
      ins = rins(FN_VADD, 5'd3, 5'd1, 5'd2, 2'b10);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));
      send(0, '0, 0, 1, 0, '0);

      // LOAD r4 then VAND r5,r4,r6: one stall cycle
      ld = iins(OPC_LOAD, 5'd4, 5'd1, 16'h0040);
      send(1, ld, 0, 1, 0, mk(ld, 64'd5, 64'h100));
      ins = rins(FN_VAND, 5'd5, 5'd4, 5'd6, 2'b00);
      send(1, ins, 0, 0, 0, '0);
      send(1, ins, 0, 1, 0, mk(ins, 64'h104, 64'h106));

      // Load-use through rB
      ld = iins(OPC_LOAD, 5'd7, 5'd2, 16'h0000);
      send(1, ld, 0, 1, 0, mk(ld, 64'd7, 64'h100));
      ins = rins(FN_VXOR, 5'd8, 5'd1, 5'd7, 2'b01);
      send(1, ins, 0, 0, 0, '0);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'h107));

      // Load-use through STORE source taken from rD field
      ld = iins(OPC_LOAD, 5'd11, 5'd1, 16'h0000);
      send(1, ld, 0, 1, 0, mk(ld, 64'd5, 64'h100));
      ins = iins(OPC_STORE, 5'd11, 5'd2, 16'h0004);
      send(1, ins, 0, 0, 0, '0);
      send(1, ins, 0, 1, 0, mk(ins, 64'd7, 64'h10B));

      // LOAD followed by independent op: no stall
      ld = iins(OPC_LOAD, 5'd9, 5'd1, 16'h0000);
      send(1, ld, 0, 1, 0, mk(ld, 64'd5, 64'h100));
      ins = rins(FN_VADD, 5'd10, 5'd1, 5'd2, 2'b11);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));

      // Unknown opcode reading a just-loaded register: NOP, no stall
      ld = iins(OPC_LOAD, 5'd15, 5'd1, 16'h0000);
      send(1, ld, 0, 1, 0, mk(ld, 64'd5, 64'h100));
      ins = iins(6'b000111, 5'd0, 5'd15, 16'h0000);
      send(1, ins, 0, 1, 0, mk(ins, 64'h10F, 64'h100));

      // Bubble between LOAD and consumer removes the hazard
      ld = iins(OPC_LOAD, 5'd16, 5'd1, 16'h0000);
      send(1, ld, 0, 1, 0, mk(ld, 64'd5, 64'h100));
      send(0, '0, 0, 1, 0, '0);
      ins = rins(FN_VAND, 5'd17, 5'd16, 5'd1, 2'b01);
      send(1, ins, 0, 1, 0, mk(ins, 64'h110, 64'd5));

      // VDIV: 3 busy cycles, next instruction visible on cycle 5
      ins = rins(FN_VDIV, 5'd12, 5'd1, 5'd2, 2'b11);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));
      ins = rins(FN_VSUB, 5'd13, 5'd1, 5'd2, 2'b10);
      send(1, ins, 0, 0, 0, '0);
      send(1, ins, 0, 0, 1, '0);
      send(1, ins, 0, 0, 1, '0);
      send(1, ins, 0, 1, 1, mk(ins, 64'd5, 64'd7));

      // VSQRT flushed during its second wait cycle
      ins = rins(FN_VSQRT, 5'd20, 5'd1, 5'd0, 2'b10);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'h100));
      filler = rins(FN_VADD, 5'd22, 5'd1, 5'd2, 2'b00);
      send(1, filler, 0, 0, 0, '0);
      send(1, filler, 0, 0, 1, '0);
      send(1, filler, 1, 1, 1, '0);
      send(0, '0, 0, 1, 0, '0);
      chk("flush_op_nop", 64'(ex_Op_code), 64'h3C);
      chk("flush_valid", 64'(ex_valid), 64'd0);

      // Flush drops the instruction presented that cycle
      send(1, filler, 1, 1, 0, '0);
      send(0, '0, 0, 1, 0, '0);

      // Writeback hitting the rA read port, then the rB read port
      cyc();
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'hAA;
      ins = rins(FN_VOR, 5'd14, 5'd1, 5'd2, 2'b00);
`ifdef ID_EX_WB_BYPASS_EN
      drive(1, ins, 0, 1, 0, mk(ins, 64'hAA, 64'd7));
      cyc();
      wb_addr = 5'd2;
      drive(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'hAA));
      cyc();
      wb_en = 1'b0;
      drive(0, '0, 0, 1, 0, '0);
`else
      drive(1, ins, 0, 0, 0, '0);
      cyc();
      wb_en = 1'b0;
      drive(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));
      cyc();
      wb_en = 1'b1; wb_addr = 5'd2;
      drive(1, ins, 0, 0, 0, '0);
      cyc();
      wb_en = 1'b0;
      drive(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));
`endif

      // Reset while a VMOD is occupying the ALU
      ins = rins(FN_VMOD, 5'd21, 5'd1, 5'd2, 2'b01);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));
      send(1, filler, 0, 0, 0, '0);
      send(1, filler, 0, 0, 1, '0);
      cyc();
      reset = 1'b0;
      if_valid = 1'b0;
      cyc();
      #2 check_reset_vals();
      reset = 1'b1;

      // Recovery after reset
      ins = rins(FN_VADD, 5'd3, 5'd1, 5'd2, 2'b10);
      send(1, ins, 0, 1, 0, mk(ins, 64'd5, 64'd7));
      send(0, '0, 0, 1, 0, '0);
      send(0, '0, 0, 1, 0, '0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
